// File: rtl/data_mem_responder.sv
// Wait-state data memory for the CPU load/store port: one request at a time,
// LATENCY stall cycles, then a one-cycle response pulse carrying load data or an error.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_write;
    logic        lat_byte;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic             access_now;
    logic             addr_err;
    logic             wr_en;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [31:0]      byte_data;
    logic [31:0]      wr_word;

    assign access_now = (state == BUSY) && (wait_cnt == 4'd0);
    assign addr_err   = (lat_addr >= LIMIT) || (!lat_byte && (lat_addr[1:0] != 2'b00));
    assign idx        = lat_addr[IDX_W+1:2];
    assign lane       = lat_addr[1:0];
    assign rd_word    = mem[idx];
    assign wr_en      = access_now && lat_write && !addr_err;

    // Byte lane extraction for loads, little-endian lane = addr[1:0].
    always_comb begin
        byte_data = 32'd0;
        case (lane)
            2'd0:    byte_data = {24'd0, rd_word[7:0]};
            2'd1:    byte_data = {24'd0, rd_word[15:8]};
            2'd2:    byte_data = {24'd0, rd_word[23:16]};
            default: byte_data = {24'd0, rd_word[31:24]};
        endcase
    end

    // Byte stores merge into the current word so the other lanes survive.
    always_comb begin
        wr_word = lat_wdata;
        if (lat_byte) begin
            wr_word = rd_word;
            case (lane)
                2'd0:    wr_word[7:0]   = lat_wdata[7:0];
                2'd1:    wr_word[15:8]  = lat_wdata[7:0];
                2'd2:    wr_word[23:16] = lat_wdata[7:0];
                default: wr_word[31:24] = lat_wdata[7:0];
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents persist across reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_word;
        end
    end

    // Handshake: a request transfers on a rising edge where req_valid and req_ready
    // are both high; req_ready is high only in IDLE, rsp_valid is a single-cycle pulse
    // with no backpressure, and rsp_rdata/rsp_err hold their value between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_byte  <= req_byte;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wait_cnt  <= LAT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= addr_err;
                        if (addr_err || lat_write) begin
                            rsp_rdata <= 32'd0;
                        end else begin
                            rsp_rdata <= lat_byte ? byte_data : rd_word;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-array reference model with edge-count timing,
// directed literal cases, held-valid throughput, a LATENCY=0 instance and random traffic.
module tb_data_mem_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_byte, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        z_valid, z_write, z_byte, z_ready;
    logic [31:0] z_addr, z_wdata;
    logic        z_rsp_valid, z_err;
    logic [31:0] z_rdata;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_valid), .req_ready(z_ready), .req_write(z_write),
        .req_byte(z_byte), .req_addr(z_addr), .req_wdata(z_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rdata), .rsp_err(z_err)
    );

    int checks = 0;
    int passed = 0;
    logic [32:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: byte-addressed store, response due LAT+1 edges after the accepting edge.
    logic [7:0]  mm [0:255];
    int unsigned cyc = 0;
    bit          pend = 1'b0;
    int unsigned pend_edge = 0;
    bit          m_write, m_byte;
    logic [31:0] m_addr, m_wdata;
    bit          exp_valid = 1'b0;
    bit          last_err = 1'b0;
    logic [31:0] last_rdata = 32'd0;
    bit          cmp_on = 1'b0;

    always @(posedge clk) begin
        cyc++;
        exp_valid = 1'b0;
        if (!reset) begin
            pend       = 1'b0;
            last_rdata = 32'd0;
            last_err   = 1'b0;
        end else if (pend && cyc == pend_edge + LAT + 1) begin
            exp_valid = 1'b1;
            last_err  = (m_addr >= DEPTH * 4) || (!m_byte && m_addr[1:0] != 2'b00);
            last_rdata = 32'd0;
            if (!last_err) begin
                if (m_write) begin
                    if (m_byte) mm[m_addr[7:0]] = m_wdata[7:0];
                    else for (int k = 0; k < 4; k++) mm[m_addr[7:0] + k] = m_wdata[8*k +: 8];
                end else if (m_byte) begin
                    last_rdata = {24'd0, mm[m_addr[7:0]]};
                end else begin
                    last_rdata = {mm[m_addr[7:0] + 3], mm[m_addr[7:0] + 2],
                                  mm[m_addr[7:0] + 1], mm[m_addr[7:0]]};
                end
            end
        end else if (pend && cyc == pend_edge + LAT + 2) begin
            pend = 1'b0;
        end else if (!pend && req_valid) begin
            pend      = 1'b1;
            pend_edge = cyc;
            m_write   = req_write;
            m_byte    = req_byte;
            m_addr    = req_addr;
            m_wdata   = req_wdata;
        end
    end

    initial begin
        wait (cmp_on);
        forever begin
            @(negedge clk);
            if (!reset)
                chk("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata},
                    {1'b1, 1'b0, 1'b0, 32'd0});
            else
                chk("cycle", {req_ready, rsp_valid, rsp_err, rsp_rdata},
                    {~pend, exp_valid, last_err, last_rdata});
        end
    end

    task automatic do_req(input bit sel, input bit w, input bit b, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output bit err, output int lat);
        bit acc;
        bit got;
        int n;
        @(negedge clk);
        #1;
        if (sel) begin
            z_valid = 1'b1; z_write = w; z_byte = b; z_addr = addr; z_wdata = wdata;
        end else begin
            req_valid = 1'b1; req_write = w; req_byte = b; req_addr = addr; req_wdata = wdata;
        end
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = sel ? z_ready : req_ready;
            @(posedge clk);
            n++;
        end
        chk("accept", 64'(acc), 1);
        lat = 0;
        got = 1'b0;
        rdata = 32'd0;
        err = 1'b0;
        while (acc && !got && lat < 40) begin
            @(negedge clk);
            lat++;
            got   = sel ? z_rsp_valid : rsp_valid;
            rdata = sel ? z_rdata : rsp_rdata;
            err   = sel ? z_err : rsp_err;
            #1;
            z_valid = 1'b0;
            req_valid = 1'b0;
        end
        z_valid = 1'b0;
        req_valid = 1'b0;
        chk("response_seen", 64'(got), 1);
    endtask

    task automatic expect_rsp(input string name, input bit sel, input bit w, input bit b,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input bit e_err, input logic [31:0] e_data);
        logic [31:0] rd;
        bit er;
        int lat;
        exp_q.push_back({e_err, e_data});
        do_req(sel, w, b, addr, wdata, rd, er, lat);
        chk({name, "_rsp"}, {er, rd}, exp_q.pop_front());
        chk({name, "_latency"}, 64'(lat), sel ? 64'd2 : 64'(LAT + 2));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", passed, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc, got, w, b, er;
        int          n, r, lat;
        int          pulses[$];
        logic [31:0] addr, rd;

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = '0; req_wdata = '0;
        z_valid = 1'b0; z_write = 1'b0; z_byte = 1'b0; z_addr = '0; z_wdata = '0;
        #1 reset = 1'b0;
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("z_reset_outputs", {z_ready, z_rsp_valid, z_err, z_rdata}, {1'b1, 1'b0, 1'b0, 32'd0});
        #1 reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b1, 1'b0, 32'(i * 4), $urandom, rd, er, lat);

        // Reset in the middle of a store must discard it.
        expect_rsp("pre_store", 1'b0, 1'b1, 1'b0, 32'h10, 32'h01020304, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            acc = req_ready;
            @(posedge clk);
            n++;
        end
        chk("rst_accept", 64'(acc), 1);
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", 64'(req_ready), 1);
            chk("rst_rsp_valid", 64'(rsp_valid), 0);
        end
        #1 reset = 1'b1;
        expect_rsp("post_reset_load", 1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0, 32'h01020304);

        expect_rsp("word_store", 1'b0, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 1'b0, 32'd0);
        expect_rsp("word_load", 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'hAABBCCDD);
        expect_rsp("byte_store", 1'b0, 1'b1, 1'b1, 32'h22, 32'hFFFFFF11, 1'b0, 32'd0);
        expect_rsp("merged_load", 1'b0, 1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'hAA11CCDD);
        expect_rsp("byte_load_3", 1'b0, 1'b0, 1'b1, 32'h23, 32'd0, 1'b0, 32'h000000AA);
        expect_rsp("byte_load_1", 1'b0, 1'b0, 1'b1, 32'h21, 32'd0, 1'b0, 32'h000000CC);
        expect_rsp("misaligned", 1'b0, 1'b0, 1'b0, 32'h21, 32'd0, 1'b1, 32'd0);
        expect_rsp("word0_store", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 32'd0);
        expect_rsp("oob_store", 1'b0, 1'b1, 1'b0, 32'h100, 32'hFFFFFFFF, 1'b1, 32'd0);
        expect_rsp("word0_intact", 1'b0, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h0BADF00D);
        expect_rsp("last_store", 1'b0, 1'b1, 1'b0, 32'hFC, 32'hCAFEBABE, 1'b0, 32'd0);
        expect_rsp("last_load", 1'b0, 1'b0, 1'b0, 32'hFC, 32'd0, 1'b0, 32'hCAFEBABE);
        expect_rsp("last_byte", 1'b0, 1'b0, 1'b1, 32'hFF, 32'd0, 1'b0, 32'h000000CA);
        expect_rsp("oob_byte", 1'b0, 1'b0, 1'b1, 32'h100, 32'd0, 1'b1, 32'd0);

        // req_valid held high: one response every LAT+3 cycles.
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'h20;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (rsp_valid) pulses.push_back(i);
        end
        chk("held_pulse_count", 64'(pulses.size()), 5);
        for (int i = 1; i < pulses.size(); i++)
            chk("held_spacing", 64'(pulses[i] - pulses[i-1]), 64'(LAT + 3));
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = rsp_valid;
        end
        #1 req_valid = 1'b0;
        chk("held_drop", 64'(got), 1);

        expect_rsp("lat0_store", 1'b1, 1'b1, 1'b0, 32'h0, 32'h12345678, 1'b0, 32'd0);
        expect_rsp("lat0_load", 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0, 32'h12345678);
        expect_rsp("lat0_byte", 1'b1, 1'b0, 1'b1, 32'h1, 32'd0, 1'b0, 32'h00000056);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (r < 7) addr = b ? 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63) * 4);
            else if (r == 7) addr = 32'($urandom_range(256, 511));
            else if (r == 8) addr = $urandom;
            else addr = 32'($urandom_range(0, 255)) | 32'd1;
            do_req(1'b0, w, b, addr, $urandom, rd, er, lat);
            chk("rand_latency", 64'(lat), 64'(LAT + 2));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the CPU datapath's load/store port. It accepts one word or byte request at a time over a valid/ready handshake, inserts a programmable number of wait cycles, then performs the access against an internal word array. It returns read data or an error flag as a one-cycle response pulse. It sits between the datapath's ALUResult/WriteData outputs and its ReadData input, replacing the zero-latency ideal data memory so that stall logic can be exercised.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words stored; byte address space is 0 .. DEPTH_WORDS*4-1.
- LATENCY, 2: wait cycles between request acceptance and response, range 0..15.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access (LDRB/STRB), 0 = word access.
- req_addr  in  32  byte address (datapath ALUResult).
- req_wdata  in  32  store data (datapath WriteData); byte stores use bits [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access rejected; qualified by rsp_valid.

## Operation
- States: IDLE, BUSY, RESP. req_ready = 1 only in IDLE.
- IDLE: on req_valid, latch write/byte/addr/wdata, load wait counter with LATENCY, go to BUSY.
- BUSY: if counter == 0, perform the access and go to RESP; otherwise decrement.
- RESP: rsp_valid = 1 for exactly this cycle, with rsp_rdata/rsp_err valid. Then go to IDLE unconditionally. There is no response backpressure.
- Error conditions, checked on the latched request:
  - addr >= DEPTH_WORDS*4
  - word access with addr[1:0] != 0
- On error: rsp_err = 1, rsp_rdata = 0, no array write.
- Word index = addr[31:2]. Little-endian: byte lane k = bits [8k+7:8k], lane = addr[1:0].
- Word load: rsp_rdata = full word.
- Byte load: rsp_rdata = {24'b0, selected lane}, zero-extended.
- Word store: entire word replaced.
- Byte store: only the selected lane is replaced with wdata[7:0]; other lanes are unchanged.
- Store response: rsp_rdata = 0, rsp_err = 0.
- Request inputs are ignored outside IDLE. A request held valid across the response is accepted again in the next IDLE cycle; the requester must drop req_valid on rsp_valid.

## Timing
- Reset asserted, at any time including mid-transaction:
  - state → IDLE, counter = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Any in-flight request is discarded, and a pending store is not performed.
- Array contents are not initialised by reset and persist across it. Benches write before reading.
- Acceptance edge E (req_valid & req_ready). rsp_valid is high in the cycle after edge E+LATENCY+1, so response latency is LATENCY+2 cycles from acceptance.
- The array write occurs on the same edge that enters RESP. A load issued immediately after a store returns the new data.
- Minimum spacing between acceptances: LATENCY+3 cycles.
- LATENCY = 0: BUSY lasts one cycle, so the response comes 2 cycles after acceptance.
- Outputs are registered. rsp_rdata and rsp_err hold their last values while rsp_valid = 0.

## Test plan
- Reset sequence: hold reset = 0 mid-BUSY during a store of 0xDEADBEEF to 0x10, then release and load 0x10. Required: the loaded value is not 0xDEADBEEF unless that value was previously written. Also check req_ready = 1 and rsp_valid = 0 throughout reset.
- Word store/load with LATENCY = 2:
  - Store 0xAABBCCDD to 0x20 → rsp_valid exactly 4 cycles after acceptance, rsp_err = 0.
  - Load 0x20 → rsp_rdata = 0xAABBCCDD.
- Byte lanes:
  - After the word above, store byte 0x11 to 0x22.
  - Word load 0x20 → 0xAA11CCDD.
  - Byte load 0x23 → 0x000000AA.
- Errors:
  - Word load at 0x21 → rsp_err = 1, rsp_rdata = 0.
  - Store to 0x100 with DEPTH_WORDS = 64 → rsp_err = 1, and the array is unchanged.
- Handshake:
  - req_valid held high continuously → one response per 5 cycles (LATENCY = 2).
  - req_ready = 0 in every non-IDLE cycle, and each rsp_valid pulse is exactly one cycle wide.
- LATENCY = 0 build: store then load of 0x12345678 at 0x0 → each response 2 cycles after acceptance, and the load returns 0x12345678.
